// File: rtl/uart_recv.sv
// uart_recv: 8N1 UART receiver. Samples the synchronised serial line near the
// middle of each bit. It reports a good byte with a one-cycle valid pulse
// and a bad stop bit with a one-cycle frame_err pulse.
module uart_recv #(
  parameter int CLK_FREQ = 100_000_000,
  parameter int BAUD     = 9600
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       din,
  output logic       valid,
  output logic [7:0] data,
  output logic       frame_err,
  output logic       busy
);

  localparam int BIT_CNT = CLK_FREQ / BAUD;
  localparam int HALF    = BIT_CNT / 2;
  localparam int CW      = (BIT_CNT > 1) ? $clog2(BIT_CNT) : 1;

  localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(BIT_CNT - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_HIGH = 3'd4
  } state_t;

  // Line synchroniser and edge-detect history.
  // These flops reset to the idle level, so reset release does not look like
  // a falling edge unless the line really is low.
  logic rx_m, rx_s, rx_d;

  state_t          state, state_next;
  logic [CW-1:0]   clk_cnt, clk_cnt_next;
  logic [2:0]      bit_idx, bit_idx_next;
  logic [7:0]      shift_reg, shift_next;
  logic [7:0]      data_next;
  logic            valid_next, frame_err_next;

  // Two-flop synchroniser on din plus one delay flop for falling-edge detect
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
      rx_d <= 1'b1;
    end else begin
      rx_m <= din;
      rx_s <= rx_m;
      rx_d <= rx_s;
    end
  end

  // Receiver state, counters and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      clk_cnt   <= '0;
      bit_idx   <= 3'd0;
      shift_reg <= 8'h00;
      data      <= 8'h00;
      valid     <= 1'b0;
      frame_err <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_next;
      clk_cnt   <= clk_cnt_next;
      bit_idx   <= bit_idx_next;
      shift_reg <= shift_next;
      data      <= data_next;
      valid     <= valid_next;
      frame_err <= frame_err_next;
      busy      <= (state_next != IDLE);
    end
  end

  // Next-state, bit timing, sampling and output-pulse decisions
  always_comb begin
    state_next     = state;
    clk_cnt_next   = clk_cnt;
    bit_idx_next   = bit_idx;
    shift_next     = shift_reg;
    data_next      = data;
    valid_next     = 1'b0;
    frame_err_next = 1'b0;

    case (state)
      IDLE: begin
        clk_cnt_next = '0;
        if (!rx_s && rx_d) begin
          state_next = START;
        end else begin
          state_next = IDLE;
        end
      end

      START: begin
        if (clk_cnt == HALF_LAST) begin
          clk_cnt_next = '0;
          if (!rx_s) begin
            state_next   = DATA;
            bit_idx_next = 3'd0;
          end else begin
            // Line went back high before mid-start: treat it as a glitch
            state_next = IDLE;
          end
        end else begin
          clk_cnt_next = clk_cnt + CNT_ONE;
        end
      end

      DATA: begin
        if (clk_cnt == BIT_LAST) begin
          clk_cnt_next        = '0;
          shift_next[bit_idx] = rx_s;
          bit_idx_next        = bit_idx + 3'd1;
          if (bit_idx == 3'd7) begin
            state_next = STOP;
          end else begin
            state_next = DATA;
          end
        end else begin
          clk_cnt_next = clk_cnt + CNT_ONE;
        end
      end

      STOP: begin
        if (clk_cnt == BIT_LAST) begin
          clk_cnt_next = '0;
          if (rx_s) begin
            data_next  = shift_reg;
            valid_next = 1'b1;
            state_next = IDLE;
          end else begin
            // Bad stop bit: hold data and wait for the line to recover
            frame_err_next = 1'b1;
            state_next     = WAIT_HIGH;
          end
        end else begin
          clk_cnt_next = clk_cnt + CNT_ONE;
        end
      end

      WAIT_HIGH: begin
        clk_cnt_next = '0;
        if (rx_s) begin
          state_next = IDLE;
        end else begin
          state_next = WAIT_HIGH;
        end
      end

      default: begin
        clk_cnt_next = '0;
        state_next   = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_recv.sv
// tb_uart_recv: directed plus randomized 8N1 frames against two receivers.
// One receiver uses small baud settings. The other uses a non-integer
// clock/baud ratio. Expected bytes and timing come from the frame rules.
module tb_uart_recv;

  // Main instance: 16 clocks per bit, mid-start sample 8 clocks after the edge
  localparam int CF   = 160;
  localparam int BD   = 10;
  localparam int BIT  = 16;
  localparam int HALF = 8;
  // din set at a negedge -> 2 sync flops -> 1 edge-detect cycle -> half + 9 bits
  localparam int LAT  = 3 + HALF + 9 * BIT;

  // Second instance: 1000/7 truncates to 142 clocks per bit, half bit is 71
  localparam int CF2   = 1000;
  localparam int BD2   = 7;
  localparam int BIT2  = 142;
  localparam int HALF2 = 71;
  localparam int LAT2  = 3 + HALF2 + 9 * BIT2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       din = 1'b1;
  logic       valid, frame_err, busy;
  logic [7:0] data;
  logic       din2 = 1'b1;
  logic       valid2, frame_err2, busy2;
  logic [7:0] data2;

  int checks   = 0;
  int failures = 0;

  int         cyc = 0;
  logic [7:0] vdata_q[$];
  int         vcyc_q[$];
  int         fall_q[$];
  int         ferr_cnt = 0, both_cnt = 0, busy_cnt = 0;
  int         v2_cnt = 0, v2_cyc = 0, ferr2_cnt = 0, fall2 = 0;
  logic [7:0] v2_data = 8'h00;

  uart_recv #(.CLK_FREQ(CF), .BAUD(BD)) dut (
    .clk(clk), .rst(rst), .din(din),
    .valid(valid), .data(data), .frame_err(frame_err), .busy(busy)
  );

  uart_recv #(.CLK_FREQ(CF2), .BAUD(BD2)) dut2 (
    .clk(clk), .rst(rst), .din(din2),
    .valid(valid2), .data(data2), .frame_err(frame_err2), .busy(busy2)
  );

  always #5 clk = ~clk;

  // Cycle counter, advanced on the active edge so negedge readers see it stable
  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor sampling away from the active edge
  always @(negedge clk) begin
    if (valid) begin
      vdata_q.push_back(data);
      vcyc_q.push_back(cyc);
    end
    if (frame_err) ferr_cnt++;
    if (valid && frame_err) both_cnt++;
    if (busy) busy_cnt++;
    if (valid2) begin
      v2_cnt++;
      v2_data = data2;
      v2_cyc  = cyc;
    end
    if (frame_err2) ferr2_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_near(input string tag, input int obs, input int exp);
    checks++;
    assert (obs >= exp - 1 && obs <= exp + 1) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d+-1", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] vdata_at(input int idx);
    if (idx < vdata_q.size()) return vdata_q[idx];
    else return 8'hxx;
  endfunction

  function automatic int vcyc_at(input int idx);
    if (idx < vcyc_q.size()) return vcyc_q[idx];
    else return -100000;
  endfunction

  task automatic line_set(input bit which, input logic v);
    if (which) din2 = v;
    else din = v;
  endtask

  // Drive one 8N1 frame starting at the current negedge; line is left at the stop level
  task automatic send_frame(input bit which, input int bitc, input logic [7:0] b, input logic stop);
    logic [9:0] bits;
    bits = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      line_set(which, bits[i]);
      if (i == 0) begin
        if (which) fall2 = cyc;
        else fall_q.push_back(cyc);
      end
      repeat (bitc) @(negedge clk);
    end
  endtask

  initial begin
    int nv, nf, nb, fb;
    logic [7:0] b;
    logic [7:0] exp_q[$];

    rst = 1'b1;
    din = 1'b1;
    din2 = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_valid", valid, 1'b0);
    check("reset_data", data, 8'h00);
    check("reset_frame_err", frame_err, 1'b0);
    check("reset_busy", busy, 1'b0);
    check("reset_busy2", busy2, 1'b0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // Single clean byte 's'
    send_frame(1'b0, BIT, 8'h73, 1'b1);
    repeat (2 * BIT) @(negedge clk);
    check("s_count", vdata_q.size(), 1);
    check("s_data", vdata_at(0), 8'h73);
    check("s_no_ferr", ferr_cnt, 0);
    check("s_busy_low", busy, 1'b0);
    check_near("s_latency", vcyc_at(0) - fall_q[0], LAT);

    // Back-to-back bytes with a single stop bit
    nv = vdata_q.size();
    send_frame(1'b0, BIT, 8'h0D, 1'b1);
    send_frame(1'b0, BIT, 8'h41, 1'b1);
    repeat (2 * BIT) @(negedge clk);
    check("b2b_count", vdata_q.size(), nv + 2);
    check("b2b_first", vdata_at(nv), 8'h0D);
    check("b2b_second", vdata_at(nv + 1), 8'h41);
    check_near("b2b_gap", vcyc_at(nv + 1) - vcyc_at(nv), 10 * BIT);

    // Short low glitch: busy for the half-bit only, nothing reported
    nv = vdata_q.size();
    nf = ferr_cnt;
    nb = busy_cnt;
    din = 1'b0;
    repeat (3) @(negedge clk);
    din = 1'b1;
    repeat (2 * BIT) @(negedge clk);
    check("glitch_busy_cycles", busy_cnt - nb, HALF);
    check("glitch_no_valid", vdata_q.size(), nv);
    check("glitch_no_ferr", ferr_cnt, nf);
    check("glitch_data_kept", data, 8'h41);
    check("glitch_busy_low", busy, 1'b0);

    // Bad stop bit, line held low two more bit periods
    send_frame(1'b0, BIT, 8'h55, 1'b0);
    repeat (2 * BIT) @(negedge clk);
    check("ferr_pulse", ferr_cnt, nf + 1);
    check("ferr_no_valid", vdata_q.size(), nv);
    check("ferr_data_kept", data, 8'h41);
    check("ferr_wait_high_busy", busy, 1'b1);
    din = 1'b1;
    repeat (4) @(negedge clk);
    check("ferr_released", busy, 1'b0);
    repeat (BIT) @(negedge clk);
    send_frame(1'b0, BIT, 8'h68, 1'b1);
    repeat (2 * BIT) @(negedge clk);
    check("after_ferr_count", vdata_q.size(), nv + 1);
    check("after_ferr_data", vdata_at(nv), 8'h68);
    check("never_both", both_cnt, 0);

    // Reset in the middle of data bit 4 of 0xA5
    nv = vdata_q.size();
    nf = ferr_cnt;
    b = 8'hA5;
    din = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      din = b[i];
      repeat (BIT) @(negedge clk);
    end
    din = b[4];
    repeat (BIT / 2) @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_valid", valid, 1'b0);
    check("abort_data", data, 8'h00);
    check("abort_frame_err", frame_err, 1'b0);
    check("abort_busy", busy, 1'b0);
    @(negedge clk);
    din = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2 * BIT) @(negedge clk);
    check("abort_no_valid", vdata_q.size(), nv);
    check("abort_no_ferr", ferr_cnt, nf);
    send_frame(1'b0, BIT, 8'h69, 1'b1);
    repeat (2 * BIT) @(negedge clk);
    check("post_abort_count", vdata_q.size(), nv + 1);
    check("post_abort_data", vdata_at(nv), 8'h69);

    // Randomized bytes with random idle gaps (zero gap = back-to-back)
    nv = vdata_q.size();
    nf = ferr_cnt;
    fb = fall_q.size();
    for (int k = 0; k < 6; k++) begin
      b = 8'($urandom_range(0, 255));
      repeat ($urandom_range(0, 3 * BIT)) @(negedge clk);
      send_frame(1'b0, BIT, b, 1'b1);
      exp_q.push_back(b);
    end
    repeat (2 * BIT) @(negedge clk);
    check("rand_count", vdata_q.size(), nv + exp_q.size());
    for (int k = 0; k < exp_q.size(); k++) begin
      check($sformatf("rand_data%0d", k), vdata_at(nv + k), exp_q[k]);
      check_near($sformatf("rand_lat%0d", k), vcyc_at(nv + k) - fall_q[fb + k], LAT);
    end
    check("rand_no_ferr", ferr_cnt, nf);
    check("rand_never_both", both_cnt, 0);

    // Truncated clock/baud ratio on the second instance
    b = 8'($urandom_range(0, 255));
    send_frame(1'b1, BIT2, b, 1'b1);
    repeat (2 * BIT2) @(negedge clk);
    check("trunc_count", v2_cnt, 1);
    check("trunc_data", v2_data, b);
    check_near("trunc_latency", v2_cyc - fall2, LAT2);
    check("trunc_no_ferr", ferr2_cnt, 0);
    check("trunc_busy_low", busy2, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
